xfer_sequencer: RTL and testbench

Control-side sequencer for a bank of `register_xfer` 16-bit transfer registers. It accepts one transfer command at a time and generates the per-register active-low strobes that move a value between registers. Three move types are supported:
- a full 16-bit copy over the xfer bus;
- a byte-split copy over the 8-bit main bus, low byte then high byte;
- a timed drive of one register onto the address bus.

It sits between the instruction decode logic and the register bank, and guarantees that exactly one source drives a bus during any strobe.

---
 rtl/xfer_sequencer.sv | 158 +++++++++++++++
 tb/tb_xfer_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/xfer_sequencer.sv
// +--------------------------------------------------------------------------+
// | xfer_sequencer: strobe sequencer for a bank of register_xfer registers.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module xfer_sequencer #(
  parameter int NREG        = 4,
  parameter int ADDR_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [$clog2(NREG)-1:0]   src,
  input  logic [$clog2(NREG)-1:0]   dst,
  input  logic [1:0]                mode,
  output logic [NREG-1:0]           assert_addr,
  output logic [NREG-1:0]           assert_xfer,
  output logic [NREG-1:0]           load_xfer,
  output logic [NREG-1:0]           assertlow_main,
  output logic [NREG-1:0]           asserthigh_main,
  output logic [NREG-1:0]           loadlow_main,
  output logic [NREG-1:0]           loadhigh_main,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int IW = $clog2(NREG);
  localparam int CW = (ADDR_CYCLES > 1) ? $clog2(ADDR_CYCLES) : 1;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_SETUP_X  = 4'd1;
  localparam logic [3:0] S_STROBE_X = 4'd2;
  localparam logic [3:0] S_HOLD_X   = 4'd3;
  localparam logic [3:0] S_SETUP_L  = 4'd4;
  localparam logic [3:0] S_STROBE_L = 4'd5;
  localparam logic [3:0] S_HOLD_L   = 4'd6;
  localparam logic [3:0] S_SETUP_H  = 4'd7;
  localparam logic [3:0] S_STROBE_H = 4'd8;
  localparam logic [3:0] S_HOLD_H   = 4'd9;
  localparam logic [3:0] S_ADDR     = 4'd10;
  localparam logic [3:0] S_DONE     = 4'd11;
  localparam logic [3:0] S_ERR      = 4'd12;

  logic [3:0]      r_state;
  logic [IW-1:0]   r_src;
  logic [IW-1:0]   r_dst;
  logic [CW-1:0]   r_cnt;
  logic [NREG-1:0] r_assert_addr, r_assert_xfer, r_load_xfer;
  logic [NREG-1:0] r_assertlow_main, r_asserthigh_main, r_loadlow_main, r_loadhigh_main;
  logic            r_busy, r_done, r_err;

  logic [3:0]      w_next;
  logic [CW-1:0]   w_cnt_next;
  logic [IW-1:0]   w_src;
  logic [IW-1:0]   w_dst;
  logic [NREG-1:0] w_src_oh;
  logic [NREG-1:0] w_dst_oh;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (mode == 2'd3 || (mode != 2'd2 && src == dst)) begin
            w_next = S_ERR;
          end else if (mode == 2'd0) begin
            w_next = S_SETUP_X;
          end else if (mode == 2'd1) begin
            w_next = S_SETUP_L;
          end else begin
            w_next     = S_ADDR;
            w_cnt_next = CW'(ADDR_CYCLES - 1);
          end
        end
      end
      S_SETUP_X:  w_next = S_STROBE_X;
      S_STROBE_X: w_next = S_HOLD_X;
      S_HOLD_X:   w_next = S_DONE;
      S_SETUP_L:  w_next = S_STROBE_L;
      S_STROBE_L: w_next = S_HOLD_L;
      S_HOLD_L:   w_next = S_SETUP_H;
      S_SETUP_H:  w_next = S_STROBE_H;
      S_STROBE_H: w_next = S_HOLD_H;
      S_HOLD_H:   w_next = S_DONE;
      S_ADDR: begin
        if (r_cnt == '0) begin
          w_next = S_DONE;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      default:    w_next = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so every output can be registered
  // without adding a cycle of latency; in IDLE the live command fields apply.
  assign w_src    = (r_state == S_IDLE) ? src : r_src;
  assign w_dst    = (r_state == S_IDLE) ? dst : r_dst;
  assign w_src_oh = NREG'(1) << w_src;
  assign w_dst_oh = NREG'(1) << w_dst;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_src             <= '0;
      r_dst             <= '0;
      r_cnt             <= '0;
      r_assert_addr     <= '1;
      r_assert_xfer     <= '1;
      r_load_xfer       <= '1;
      r_assertlow_main  <= '1;
      r_asserthigh_main <= '1;
      r_loadlow_main    <= '1;
      r_loadhigh_main   <= '1;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_err             <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (r_state == S_IDLE) begin
        r_src <= src;
        r_dst <= dst;
      end
      r_assert_xfer     <= (w_next == S_SETUP_X || w_next == S_STROBE_X || w_next == S_HOLD_X)
                           ? ~w_src_oh : '1;
      r_load_xfer       <= (w_next == S_STROBE_X) ? ~w_dst_oh : '1;
      r_assertlow_main  <= (w_next == S_SETUP_L || w_next == S_STROBE_L || w_next == S_HOLD_L)
                           ? ~w_src_oh : '1;
      r_loadlow_main    <= (w_next == S_STROBE_L) ? ~w_dst_oh : '1;
      r_asserthigh_main <= (w_next == S_SETUP_H || w_next == S_STROBE_H || w_next == S_HOLD_H)
                           ? ~w_src_oh : '1;
      r_loadhigh_main   <= (w_next == S_STROBE_H) ? ~w_dst_oh : '1;
      r_assert_addr     <= (w_next == S_ADDR) ? ~w_src_oh : '1;
      r_busy            <= (w_next != S_IDLE);
      r_done            <= (w_next == S_DONE || w_next == S_ERR);
      r_err             <= (w_next == S_ERR);
    end
  end

  assign assert_addr     = r_assert_addr;
  assign assert_xfer     = r_assert_xfer;
  assign load_xfer       = r_load_xfer;
  assign assertlow_main  = r_assertlow_main;
  assign asserthigh_main = r_asserthigh_main;
  assign loadlow_main    = r_loadlow_main;
  assign loadhigh_main   = r_loadhigh_main;
  assign busy            = r_busy;
  assign done            = r_done;
  assign err             = r_err;

endmodule

`default_nettype wire

// File: tb/tb_xfer_sequencer.sv
// +--------------------------------------------------------------------------+
// | tb_xfer_sequencer: scoreboard bench for xfer_sequencer with a bank model.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_xfer_sequencer;

  localparam int NREG = 4;
  localparam int AC   = 2;

  typedef struct packed {
    logic [NREG-1:0] aa, ax, lx, alm, ahm, lolm, lohm;
    logic            busy, done, err;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [1:0]      src = '0, dst = '0, mode = '0;
  logic [NREG-1:0] assert_addr, assert_xfer, load_xfer;
  logic [NREG-1:0] assertlow_main, asserthigh_main, loadlow_main, loadhigh_main;
  logic            busy, done, err;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic [15:0] regs [NREG];
  logic        preset = 1'b1;

  xfer_sequencer #(.NREG(NREG), .ADDR_CYCLES(AC)) u_dut (
    .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .mode(mode),
    .assert_addr(assert_addr), .assert_xfer(assert_xfer), .load_xfer(load_xfer),
    .assertlow_main(assertlow_main), .asserthigh_main(asserthigh_main),
    .loadlow_main(loadlow_main), .loadhigh_main(loadhigh_main),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural register bank: sources drive buses, loads capture at the edge.
  always @(posedge clk) begin
    logic [15:0] xbus;
    logic [7:0]  mbus;
    xbus = '0;
    mbus = '0;
    for (int i = 0; i < NREG; i++) begin
      if (!assert_xfer[i])     xbus = regs[i];
      if (!assertlow_main[i])  mbus = regs[i][7:0];
      if (!asserthigh_main[i]) mbus = regs[i][15:8];
    end
    for (int i = 0; i < NREG; i++) begin
      if (preset) begin
        regs[i] <= (i == 0) ? 16'hA55A : (i == 1) ? 16'h1234 : 16'h0000;
      end else begin
        if (!load_xfer[i])     regs[i]       <= xbus;
        if (!loadlow_main[i])  regs[i][7:0]  <= mbus;
        if (!loadhigh_main[i]) regs[i][15:8] <= mbus;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e = '{aa: '1, ax: '1, lx: '1, alm: '1, ahm: '1, lolm: '1, lohm: '1,
          busy: 1'b0, done: 1'b0, err: 1'b0};
    return e;
  endfunction

  function automatic int cmd_len(input int md, input int s, input int d);
    if (md == 3 || (md < 2 && s == d)) return 1;
    if (md == 0) return 4;
    if (md == 1) return 7;
    return AC + 1;
  endfunction

  // Expected outputs in cycle c (1-based) after the start edge.
  function automatic exp_t model(input int md, input int s, input int d, input int c);
    exp_t            e;
    logic [NREG-1:0] so, dn;
    int              len;
    e   = idle_exp();
    so  = ~(NREG'(1) << s);
    dn  = ~(NREG'(1) << d);
    len = cmd_len(md, s, d);
    if (c > len) return e;
    e.busy = 1'b1;
    if (c == len) begin
      e.done = 1'b1;
      e.err  = (len == 1);
      return e;
    end
    case (md)
      0: begin
        e.ax = so;
        if (c == 2) e.lx = dn;
      end
      1: begin
        if (c <= 3) e.alm = so; else e.ahm = so;
        if (c == 2) e.lolm = dn;
        if (c == 5) e.lohm = dn;
      end
      default: e.aa = so;
    endcase
    return e;
  endfunction

  task automatic cmp_exp(input string tag, input exp_t e);
    check_eq({tag, " assert_addr"},     32'(assert_addr),     32'(e.aa));
    check_eq({tag, " assert_xfer"},     32'(assert_xfer),     32'(e.ax));
    check_eq({tag, " load_xfer"},       32'(load_xfer),       32'(e.lx));
    check_eq({tag, " assertlow_main"},  32'(assertlow_main),  32'(e.alm));
    check_eq({tag, " asserthigh_main"}, 32'(asserthigh_main), 32'(e.ahm));
    check_eq({tag, " loadlow_main"},    32'(loadlow_main),    32'(e.lolm));
    check_eq({tag, " loadhigh_main"},   32'(loadhigh_main),   32'(e.lohm));
    check_eq({tag, " busy"},            32'(busy),            32'(e.busy));
    check_eq({tag, " done"},            32'(done),            32'(e.done));
    check_eq({tag, " err"},             32'(err),             32'(e.err));
  endtask

  // rst_at>0 asserts reset after checking that cycle; ign_at>0 pulses a stray start.
  task automatic run_cmd(input int md, input int s, input int d, input int rst_at, input int ign_at);
    int   len, total;
    exp_t e;
    len   = cmd_len(md, s, d);
    total = (rst_at > 0) ? rst_at + 1 : len + 2;
    for (int c = 1; c <= total; c++) begin
      e = (rst_at > 0 && c > rst_at) ? idle_exp() : model(md, s, d, c);
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b1;
    src   = 2'(s);
    dst   = 2'(d);
    mode  = 2'(md);
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      start = 1'b0;
      src   = 2'($urandom);
      dst   = 2'($urandom);
      mode  = 2'($urandom);
      if (sb.size() == 0) begin
        check_eq("scoreboard underrun", 32'(0), 32'(1));
      end else begin
        e = sb.pop_front();
        cmp_exp($sformatf("m%0d s%0d d%0d c%0d", md, s, d, c), e);
      end
      if (c == ign_at) begin
        start = 1'b1;
        src   = 2'd0;
        dst   = 2'd1;
        mode  = 2'd0;
      end
      if (c == rst_at) reset = 1'b1;
    end
    reset = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    cmp_exp("reset", idle_exp());
    reset  = 1'b0;
    preset = 1'b0;

    run_cmd(0, 1, 2, 0, 0);
    check_eq("bank r2 after xfer copy", 32'(regs[2]), 32'h1234);
    run_cmd(1, 0, 3, 0, 0);
    check_eq("bank r3 after split copy", 32'(regs[3]), 32'hA55A);
    run_cmd(2, 3, 0, 0, 2);
    run_cmd(3, 1, 2, 0, 0);
    run_cmd(0, 2, 2, 0, 0);
    run_cmd(1, 0, 1, 5, 0);
    run_cmd(0, 2, 0, 0, 0);
    check_eq("bank r0 after post-reset copy", 32'(regs[0]), 32'h1234);
    run_cmd(1, 3, 2, 0, 0);
    check_eq("bank r2 after split copy", 32'(regs[2]), 32'hA55A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
